instruction_sequencer: RTL

- Multi-cycle fetch/decode/execute/writeback controller that sits directly upstream of the 8×16 register file.
- Fetches 16-bit instructions from an asynchronous instruction ROM.
- Drives the register file's two read addresses, write address, write enable and write data.
- Consumes RD1/RD2 and computes results with an internal ALU; it is the CPU core's control and execute stage.

---
 rtl/instruction_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Purpose : multi-cycle fetch/decode/execute/writeback controller + ALU in front of an 8x16 register file.
// Latency : 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK), plus a PAUSE state when single-step is built in.
// Backpr. : none; the ROM and register file are assumed to answer within one cycle, Start is ignored while Busy.
//
// Ports: clk/rst_n (async active-low); Start (level, leaves IDLE); Step (single-step advance);
//        Instr/InstrAddr (async ROM); Address1/2 + RD1/RD2 (register reads, held DECODE..WRITEBACK);
//        Address3/WE/WriteData (register write, WRITEBACK only); Zero/Carry flags; Halted; Busy.
// Build option: SEQ_SINGLE_STEP_EN inserts a PAUSE state after WRITEBACK that waits for Step.
module instruction_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic              Step,
    input  logic [15:0]       Instr,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic [2:0]        Address1,
    output logic [2:0]        Address2,
    output logic [2:0]        Address3,
    output logic              WE,
    output logic [15:0]       WriteData,
    input  logic [15:0]       RD1,
    input  logic [15:0]       RD2,
    output logic              Zero,
    output logic              Carry,
    output logic              Halted,
    output logic              Busy
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE     = 3'd5,
`endif
        S_HALTED    = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       ir;
    logic [ADDR_W-1:0] pc_nxt;      // PC resolved in EXECUTE, committed when leaving WRITEBACK
    logic              fetch_stb;
    logic              exec_stb;
    logic              wb_stb;

    logic [3:0]        op;
    logic [3:0]        fetch_op;
    logic [15:0]       alu_res;
    logic              alu_c;
    logic              alu_wr;
    logic [16:0]       alu_sum;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_res;

    assign op       = ir[15:12];
    assign fetch_op = Instr[15:12];
    assign pc_inc   = InstrAddr + ADDR_W'(1);

`ifndef SEQ_SINGLE_STEP_EN
    logic unused_step;
    assign unused_step = Step;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (Start) state_nxt = S_FETCH;
            S_FETCH:     state_nxt = S_DECODE;
            S_DECODE:    state_nxt = S_EXECUTE;
            S_EXECUTE:   state_nxt = (op == OP_HALT) ? S_HALTED : S_WRITEBACK;
`ifdef SEQ_SINGLE_STEP_EN
            S_WRITEBACK: state_nxt = S_PAUSE;
            S_PAUSE:     if (Step) state_nxt = S_FETCH;
`else
            S_WRITEBACK: state_nxt = S_FETCH;
`endif
            S_HALTED:    state_nxt = S_HALTED;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        Busy      = 1'b1;
        fetch_stb = 1'b0;
        exec_stb  = 1'b0;
        wb_stb    = 1'b0;
        unique case (state)
            S_IDLE, S_HALTED: Busy      = 1'b0;
            S_FETCH:          fetch_stb = 1'b1;
            S_EXECUTE:        exec_stb  = 1'b1;
            S_WRITEBACK:      wb_stb    = 1'b1;
            default:          ;
        endcase
    end

    // ---------------- ALU and branch resolution (EXECUTE) ----------------
    always_comb begin
        alu_res = '0;
        alu_c   = Carry;
        alu_sum = '0;
        alu_wr  = (op >= OP_ADD) && (op <= OP_ADDI);
        pc_res  = pc_inc;
        unique case (op)
            OP_ADD: begin
                alu_sum = {1'b0, RD1} + {1'b0, RD2};
                alu_res = alu_sum[15:0];
                alu_c   = alu_sum[16];
            end
            OP_SUB: begin
                alu_res = RD1 - RD2;
                alu_c   = (RD1 < RD2);
            end
            OP_AND: begin alu_res = RD1 & RD2; alu_c = 1'b0; end
            OP_OR:  begin alu_res = RD1 | RD2; alu_c = 1'b0; end
            OP_XOR: begin alu_res = RD1 ^ RD2; alu_c = 1'b0; end
            OP_SHL: begin alu_res = RD1 << RD2[3:0]; alu_c = 1'b0; end
            OP_SHR: begin alu_res = RD1 >> RD2[3:0]; alu_c = 1'b0; end
            OP_LDI: alu_res = {{7{ir[8]}}, ir[8:0]};
            OP_ADDI: begin
                alu_sum = {1'b0, RD1} + {1'b0, {10{ir[5]}}, ir[5:0]};
                alu_res = alu_sum[15:0];
                alu_c   = alu_sum[16];
            end
            // For BEQ, RD1 carries R[rd] and RD2 carries R[rs1] (see address steering below).
            OP_BEQ: if (RD1 == RD2) pc_res = pc_inc + ADDR_W'($signed(ir[5:0]));
            OP_JMP: pc_res = ir[ADDR_W-1:0];
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir        <= '0;
            InstrAddr <= RESET_PC;
            pc_nxt    <= RESET_PC;
            Address1  <= '0;
            Address2  <= '0;
            Address3  <= '0;
            WE        <= 1'b0;
            WriteData <= '0;
            Zero      <= 1'b0;
            Carry     <= 1'b0;
            Halted    <= 1'b0;
        end else begin
            // Read addresses are taken straight from the ROM word so they are
            // already valid throughout DECODE; registered register files then
            // still have data by the end of EXECUTE.
            if (fetch_stb) begin
                ir       <= Instr;
                Address1 <= (fetch_op == OP_BEQ) ? Instr[11:9] : Instr[8:6];
                Address2 <= (fetch_op == OP_BEQ) ? Instr[8:6]  : Instr[5:3];
            end
            if (exec_stb) begin
                WriteData <= alu_res;
                Address3  <= ir[11:9];
                WE        <= alu_wr;
                pc_nxt    <= pc_res;
                if (alu_wr) begin
                    Zero  <= (alu_res == 16'h0000);
                    Carry <= alu_c;
                end
                if (op == OP_HALT) Halted <= 1'b1;
            end
            if (wb_stb) begin
                WE        <= 1'b0;
                InstrAddr <= pc_nxt;
            end
        end
    end

endmodule
